// File: rtl/mem_pkg.sv
// Shared constants and boot-state encoding for the memory responder.
package mem_pkg;

  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned PW    = AW + 1;

  typedef enum logic [2:0] {
    StHdr,
    StImem,
    StDmem,
    StRun,
    StErr
  } boot_state_e;

endpackage

// File: rtl/sync_ram_1w1r.sv
// Small register-file RAM: synchronous write, asynchronous read, synchronous clear.
module sync_ram_1w1r #(
  parameter int unsigned AddrW = 5,
  parameter int unsigned DataW = 8,
  parameter int unsigned Depth = 32
) (
  input  logic             clk_i,
  input  logic             clear_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [DataW-1:0] rdata_o
);

  logic [DataW-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/memory_responder.sv
// Instruction/data memories for the accumulator CPU plus the boot loader that fills them
// from a byte stream and holds the CPU in reset until the image is complete.
module memory_responder
  import mem_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          load_valid,
  input  logic [DW-1:0] load_data,
  input  logic          load_last,
  output logic          load_ready,
  output logic          load_done,
  output logic          load_err,
  output logic          cpu_reset,
  input  logic [AW-1:0] im_abus,
  output logic [DW-1:0] im_dbus,
  input  logic [AW-1:0] dm_abus,
  input  logic [DW-1:0] dm_in_dbus,
  input  logic          dm_we,
  output logic [DW-1:0] dm_out_dbus
);

  boot_state_e   state_q, state_d;
  logic [PW-1:0] count_q, count_d;
  logic [PW-1:0] iptr_q, iptr_d;
  logic [PW-1:0] dptr_q, dptr_d;

  logic          accept;
  logic          im_we;
  logic          dm_wr_en;
  logic [AW-1:0] dm_waddr;
  logic [DW-1:0] dm_wdata;
  logic          dptr_full;
  logic [PW-1:0] iptr_inc;

  assign load_ready = (state_q == StHdr) || (state_q == StImem) || (state_q == StDmem);
  assign load_done  = (state_q == StRun);
  assign load_err   = (state_q == StErr);
  assign cpu_reset  = (state_q != StRun);

  assign accept    = load_valid && load_ready;
  assign dptr_full = (dptr_q == PW'(DEPTH));
  assign iptr_inc  = iptr_q + PW'(1);

  assign im_we = accept && (state_q == StImem);

  // Loader owns dmem until RUN; afterwards only the CPU writes it.
  always_comb begin
    dm_wr_en = 1'b0;
    dm_waddr = dm_abus;
    dm_wdata = dm_in_dbus;
    if (state_q == StRun) begin
      dm_wr_en = dm_we;
    end else if (state_q == StDmem) begin
      dm_wr_en = accept && !dptr_full;
      dm_waddr = dptr_q[AW-1:0];
      dm_wdata = load_data;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    iptr_d  = iptr_q;
    dptr_d  = dptr_q;
    unique case (state_q)
      StHdr: begin
        if (accept) begin
          if (load_data == '0 || load_data > DW'(DEPTH) || load_last) begin
            state_d = StErr;
          end else begin
            count_d = load_data[PW-1:0];
            state_d = StImem;
          end
        end
      end
      StImem: begin
        if (accept) begin
          iptr_d = iptr_inc;
          if (iptr_inc == count_q) begin
            state_d = load_last ? StRun : StDmem;
          end else if (load_last) begin
            state_d = StErr;
          end
        end
      end
      StDmem: begin
        if (accept) begin
          if (dptr_full) begin
            state_d = StErr;
          end else begin
            dptr_d = dptr_q + PW'(1);
            if (load_last) state_d = StRun;
          end
        end
      end
      StRun:   state_d = StRun;
      StErr:   state_d = StErr;
      default: state_d = StErr;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StHdr;
      count_q <= '0;
      iptr_q  <= '0;
      dptr_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      iptr_q  <= iptr_d;
      dptr_q  <= dptr_d;
    end
  end

  sync_ram_1w1r #(
    .AddrW(AW),
    .DataW(DW),
    .Depth(DEPTH)
  ) u_imem (
    .clk_i  (clk),
    .clear_i(reset),
    .we_i   (im_we),
    .waddr_i(iptr_q[AW-1:0]),
    .wdata_i(load_data),
    .raddr_i(im_abus),
    .rdata_o(im_dbus)
  );

  sync_ram_1w1r #(
    .AddrW(AW),
    .DataW(DW),
    .Depth(DEPTH)
  ) u_dmem (
    .clk_i  (clk),
    .clear_i(reset),
    .we_i   (dm_wr_en),
    .waddr_i(dm_waddr),
    .wdata_i(dm_wdata),
    .raddr_i(dm_abus),
    .rdata_o(dm_out_dbus)
  );

endmodule

// File: doc/memory_responder.md
Name: memory_responder

Overview:
- Memory-side responder for the single-cycle accumulator datapath.
- Serves the instruction bus (im_abus/im_dbus) and data bus (dm_abus/dm_in_dbus/dm_out_dbus).
- Before the CPU may run, a boot FSM loads a program image into both memories over a byte-wide valid/ready stream. It holds the CPU in reset until loading succeeds.

Parameters:
- AW, 5, address width of both memories.
- DW, 8, data/instruction width.
- DEPTH, 32, words per memory; equals 2**AW.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- load_valid  input  1  load stream byte valid.
- load_data  input  DW  load stream byte.
- load_last  input  1  marks final byte of the image; qualified by load_valid.
- load_ready  output  1  responder accepts a byte this cycle.
- load_done  output  1  image loaded, CPU released.
- load_err  output  1  malformed image; sticky until reset.
- cpu_reset  output  1  reset to the datapath program counter.
- im_abus  input  AW  instruction address from the CPU.
- im_dbus  output  DW  instruction word.
- dm_abus  input  AW  data address from the CPU.
- dm_in_dbus  input  DW  CPU write data (accumulator value).
- dm_we  input  1  CPU data write strobe.
- dm_out_dbus  output  DW  data read word.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to HDR.
  - Both memory arrays cleared to 8'h00.
  - Instruction count, instruction pointer and data pointer cleared.
  - Outputs after reset: load_ready=1, load_done=0, load_err=0, cpu_reset=1.
  - Reset asserted mid-load or mid-run aborts everything and restarts at HDR with cleared memories.
- Reads: im_dbus = imem[im_abus] and dm_out_dbus = dmem[dm_abus]. Both are combinational, zero latency, valid in every state. This is required by the single-cycle CPU.
- Accept: a byte is accepted when load_valid && load_ready on a rising edge. load_ready is a pure function of state: 1 in HDR, IMEM and DMEM; 0 in RUN and ERR.
- Image format:
  - Byte 0 = N, the instruction count.
  - Then N instruction bytes, written to imem[0..N-1].
  - Then 0..DEPTH data bytes, written to dmem[0..].
  - load_last marks the final byte.
- HDR:
  - Accepted byte with 1 <= N <= DEPTH and load_last=0: store N, go to IMEM.
  - N=0, N>DEPTH, or load_last=1: go to ERR.
- IMEM:
  - Each accepted byte writes imem[iptr] and increments iptr.
  - load_last on byte number N: go to RUN; no data image, dmem stays zero.
  - load_last before byte N: write that byte, then go to ERR.
  - Byte N with load_last=0: go to DMEM.
- DMEM:
  - Each accepted byte writes dmem[dptr] and increments dptr.
  - load_last: go to RUN.
  - A byte arriving when dptr=DEPTH (33rd data byte): not written, go to ERR.
- RUN:
  - cpu_reset=0, load_done=1, load_ready=0.
  - dm_we=1 writes dm_in_dbus to dmem[dm_abus] on the edge. The written value is visible on dm_out_dbus the following cycle.
  - Load stream ignored. Stays in RUN until reset.
- dm_we outside RUN is ignored; the CPU is in reset and the loader owns dmem.
- ERR: load_err=1, cpu_reset=1, load_ready=0, load_done=0. Memories keep their partial contents. Exits only on reset.
- Release timing: the final byte is accepted on edge k. load_done rises and cpu_reset falls immediately after edge k, both registered. The CPU's first fetch (address 0) happens at edge k+1.
- Pointer widths are AW+1 bits so the value DEPTH is representable; no wrap-around.

Decomposition:
- Shared package (mem_pkg) holds:
  - AW, DW, DEPTH constants.
  - Boot state enum: HDR, IMEM, DMEM, RUN, ERR.
- One natural sub-module: sync_ram_1w1r. It provides a synchronous write port, an asynchronous read port and a synchronous clear.
  - Instantiated twice: imem and dmem.
  - Write-port muxing (loader vs CPU) and the FSM stay in the top level.

Test Plan:
- Load N=3 instructions {8'hA1, 8'hC2, 8'hE3}, then data {8'h05, 8'h07} with load_last on 8'h07 -> load_done=1 and cpu_reset=0 one edge later; imem[0..2] and dmem[0..1] match; im_abus=1 gives 8'hC2.
- Header N=0 -> load_err=1, load_ready=0, cpu_reset stays 1; reset -> back to HDR with load_ready=1 and memories reading 8'h00.
- N=4 with load_last on the 2nd instruction byte -> ERR; imem[1] holds that byte; load_done never asserts.
- N=1, then 33 data bytes (no load_last through the 32nd) -> the 33rd byte is not written; ERR asserted; dmem[31] holds the 32nd byte.
- RUN: dm_we=1, dm_abus=5'd9, dm_in_dbus=8'h3C -> dm_out_dbus=8'h3C next cycle. The same write during HDR leaves dmem[9]=8'h00.
- Reset asserted in RUN and during DMEM -> next cycle: state HDR, cpu_reset=1, load_done=0, all locations read 8'h00.
